// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - keypad sync/debounce/priority sequencer and hex entry register; optional auto-repeat via KEYENTRY_AUTOREPEAT_EN
module keypad_entry_ctrl #(
  parameter int DEBOUNCE = 2,
  parameter int NDIG     = 8,
  parameter int REPEAT   = 50
) (
  input  logic              hz100,
  input  logic              reset,
  input  logic [15:0]       keys,
  input  logic              clr,
  input  logic              enter,
  input  logic              bksp,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   shown,
  output logic [3:0]        count,
  output logic              full,
  output logic [4*NDIG-1:0] value,
  output logic              done
);

  localparam int            DW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [4:0]    EV_BKSP  = 5'd16;
  localparam logic [4:0]    EV_ENTER = 5'd17;
  localparam logic [4:0]    EV_CLR   = 5'd18;
  localparam logic [4:0]    EV_NONE  = 5'd31;
  localparam logic [3:0]    NDIG_CNT = 4'(NDIG);

  // Reject parameter values the counters and the 4-bit count cannot represent.
  if (DEBOUNCE < 1 || NDIG < 1 || NDIG > 8 || REPEAT < 2) begin : g_bad_param
    $error("keypad_entry_ctrl: unsupported parameter value");
  end

  typedef enum logic [1:0] {IDLE, DEB, ACT, HOLD} state_t;

  state_t            state, state_nxt;
  logic [18:0]       sync_a, sync_b;
  logic [4:0]        code;
  logic [4:0]        held;
  logic [DW-1:0]     deb_cnt;
  logic [4*NDIG-1:0] digits_shl, digits_shr;

`ifdef KEYENTRY_AUTOREPEAT_EN
  localparam int            RW       = (REPEAT > 2) ? $clog2(REPEAT) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT - 1);
  logic [RW-1:0] rpt_cnt;
  logic          rpt_block;
  logic          rpt_ok;
  // Only hex keys and backspace repeat, and only while the same code is held throughout.
  assign rpt_ok = (held <= EV_BKSP) && !rpt_block && (code == held);
`endif

  // Two-flop synchroniser for all 19 asynchronous inputs.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {clr, enter, bksp, keys};
      sync_b <= sync_a;
    end
  end

  // Priority encoder: later assignments win, so clr beats enter beats bksp beats keys[15..0].
  always_comb begin
    code = EV_NONE;
    for (int i = 0; i < 16; i++) begin
      if (sync_b[i]) code = 5'(i);
    end
    if (sync_b[16]) code = EV_BKSP;
    if (sync_b[17]) code = EV_ENTER;
    if (sync_b[18]) code = EV_CLR;
  end

  // FSM state register.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (code != EV_NONE) state_nxt = DEB;
      DEB: begin
        if (code != held)              state_nxt = IDLE;
        else if (deb_cnt == DEB_LAST)  state_nxt = ACT;
      end
      ACT:  state_nxt = HOLD;
      HOLD: begin
        if (code == EV_NONE) state_nxt = IDLE;
`ifdef KEYENTRY_AUTOREPEAT_EN
        else if (rpt_ok && rpt_cnt == RPT_LAST) state_nxt = ACT;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latched event code and debounce counter.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      held    <= EV_NONE;
      deb_cnt <= '0;
    end else begin
      if (state == IDLE && code != EV_NONE) begin
        held    <= code;
        deb_cnt <= '0;
      end else if (state == DEB && code == held && deb_cnt != DEB_LAST) begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

`ifdef KEYENTRY_AUTOREPEAT_EN
  // Repeat timer: starts at 1 on each ACT so the next ACT lands REPEAT cycles later.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      rpt_cnt   <= '0;
      rpt_block <= 1'b0;
    end else if (state == ACT) begin
      rpt_cnt   <= RW'(1);
      rpt_block <= 1'b0;
    end else if (state == HOLD) begin
      if (code != held)             rpt_block <= 1'b1;
      else if (rpt_cnt != RPT_LAST) rpt_cnt   <= rpt_cnt + 1'b1;
    end
  end
`endif

  assign digits_shl = (digits << 4) | (4*NDIG)'(held[3:0]);
  assign digits_shr = digits >> 4;

  // Entry register: applies the latched event once per ACT cycle.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      digits <= '0;
      count  <= '0;
      value  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ACT) begin
        if (held < EV_BKSP) begin
          if (count < NDIG_CNT) begin
            digits <= digits_shl;
            count  <= count + 4'd1;
          end
        end else if (held == EV_BKSP) begin
          if (count != 4'd0) begin
            digits <= digits_shr;
            count  <= count - 4'd1;
          end
        end else if (held == EV_CLR) begin
          digits <= '0;
          count  <= '0;
        end else if (held == EV_ENTER) begin
          value  <= digits;
          done   <= 1'b1;
          digits <= '0;
          count  <= '0;
        end
      end
    end
  end

  // Digit-enable mask and full flag decoded from the registered count.
  always_comb begin
    shown = '0;
    for (int i = 0; i < NDIG; i++) begin
      shown[i] = (4'(i) < count);
    end
    full = (count == NDIG_CNT);
  end

endmodule
